stream_byte_packer: RTL and testbench

STREAM_BYTE_PACKER -- requirements
Module: stream_byte_packer

---
 rtl/stream_byte_packer.sv | 97 +++++++++
 tb/tb_stream_byte_packer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_byte_packer.sv
// Byte-to-word packer: gathers bytes little-endian into 32-bit words
// and queues them, with their byte counts, in a small output FIFO.
module stream_byte_packer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    input  logic                     flush,
    output logic [31:0]              out_data,
    output logic [2:0]               out_bytes,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [31:0]   acc;
    logic [1:0]    idx;
    logic [31:0]   word;
    logic [2:0]    word_bytes;
    logic          push;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;

    logic [31:0]   mem_data  [DEPTH];
    logic [2:0]    mem_bytes [DEPTH];

    // Bytes above idx in acc are always zero, so a partial word
    // comes out zero-padded without extra masking.
    always_comb begin
        word = acc;
        if (in_valid) begin
            word[8*idx +: 8] = in_data;
        end
        word_bytes = {1'b0, idx} + {2'b00, in_valid};
        push = (in_valid && idx == 2'd3)
            || (flush && (in_valid || idx != 2'd0));
        out_valid = count != '0;
        full  = count == LW'(DEPTH);
        pop   = out_valid && out_ready;
        wr_en = push && (!full || pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            idx      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                acc <= '0;
                idx <= '0;
            end else if (in_valid) begin
                acc <= word;
                idx <= idx + 2'd1;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_en, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_data[wr_ptr]  <= word;
            mem_bytes[wr_ptr] <= word_bytes;
        end
    end

    assign out_data  = out_valid ? mem_data[rd_ptr]  : 32'd0;
    assign out_bytes = out_valid ? mem_bytes[rd_ptr] : 3'd0;
    assign level     = count;

endmodule

// File: tb/tb_stream_byte_packer.sv
// Directed bench for stream_byte_packer: packing, flush, FIFO
// full/overflow behaviour and reset, against hand-computed words.
module tb_stream_byte_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        flush;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  level;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    stream_byte_packer #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .flush     (flush),
        .out_data  (out_data),
        .out_bytes (out_bytes),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_data"},  out_data,        32'd0);
        check({tag, "_bytes"}, 32'(out_bytes), 32'd0);
        check({tag, "_level"}, 32'(level),     32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_idle("reset");
        check("reset_ovf", 32'(overflow), 32'd0);

        // four bytes make one full word, visible for one cycle
        out_ready = 1'b1;
        send(8'h11);
        send(8'h22);
        send(8'h33);
        check("w4_early", 32'(out_valid), 32'd0);
        send(8'h44);
        check("w4_valid", 32'(out_valid), 32'd1);
        check("w4_data",  out_data,        32'h44332211);
        check("w4_bytes", 32'(out_bytes), 32'd4);
        step();
        check_idle("w4_gone");

        // partial word by flush, held while not ready
        out_ready = 1'b0;
        send(8'hAA);
        send(8'hBB);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl2_data",  out_data,        32'h0000BBAA);
        check("fl2_bytes", 32'(out_bytes), 32'd2);
        check("fl2_level", 32'(level),     32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl0_level", 32'(level),     32'd1);
        check("hold_data", out_data,        32'h0000BBAA);
        check("hold_bytes", 32'(out_bytes), 32'd2);
        out_ready = 1'b1;
        step();
        check_idle("fl2_gone");

        // byte plus flush at index 0 and at index 2
        out_ready = 1'b0;
        flush = 1'b1;
        send(8'hCC);
        flush = 1'b0;
        check("fl1_data",  out_data,        32'h000000CC);
        check("fl1_bytes", 32'(out_bytes), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        send(8'hD1);
        send(8'hD2);
        flush = 1'b1;
        send(8'hD3);
        flush = 1'b0;
        check("fl3_data",  out_data,        32'h00D3D2D1);
        check("fl3_bytes", 32'(out_bytes), 32'd3);
        out_ready = 1'b1;
        step();
        check_idle("fl3_gone");

        // overflow: 20 bytes into a 4-word FIFO without draining
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(8'(8'h40 + i));
        check("full_level", 32'(level),     32'd4);
        check("full_ovf",   32'(overflow), 32'd0);
        for (int i = 16; i < 20; i++) send(8'(8'h40 + i));
        check("ovf_level", 32'(level),     32'd4);
        check("ovf_flag",  32'(overflow), 32'd1);
        out_ready = 1'b1;
        check("ovf_w0", out_data, 32'h43424140);
        step();
        check("ovf_w1", out_data, 32'h47464544);
        step();
        check("ovf_w2", out_data, 32'h4B4A4948);
        step();
        check("ovf_w3", out_data, 32'h4F4E4D4C);
        step();
        check_idle("ovf_drain");
        check("ovf_sticky", 32'(overflow), 32'd1);

        // push and pop together while full
        do_reset();
        check("rst_ovf", 32'(overflow), 32'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(8'(8'h80 + i));
        send(8'hE1);
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        check("pp_level", 32'(level),     32'd4);
        check("pp_ovf",   32'(overflow), 32'd0);
        check("pp_w1",    out_data,       32'h87868584);
        step();
        check("pp_w2", out_data, 32'h8B8A8988);
        step();
        check("pp_w3", out_data, 32'h8F8E8D8C);
        step();
        check("pp_w4", out_data, 32'h000000E1);
        check("pp_b4", 32'(out_bytes), 32'd1);
        step();
        check_idle("pp_drain");

        // reset mid-operation discards queue and partial word
        out_ready = 1'b0;
        for (int i = 1; i <= 11; i++) send(8'(i));
        check("pre_rst_level", 32'(level), 32'd2);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        rst       = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        check_idle("mid_rst");
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i <= 4; i++) send(8'(i));
        check("post_rst_data",  out_data,        32'h04030201);
        check("post_rst_bytes", 32'(out_bytes), 32'd4);
        check("post_rst_level", 32'(level),     32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
